linear_requant_argmax: RTL and testbench
========================================

# linear_requant_argmax

Downstream stage of the linear-layer MAC accumulators. It consumes the NUM_OUT signed 32-bit neuron accumulators of one frame and requantizes each to int8 (fixed-point multiply, rounding right shift, saturation). It streams the int8 results to the next layer buffer and reports the arg-max class index and value once the frame completes.

## Interface
- NUM_OUT, 10: number of output neurons per frame (≥2).
- IDX_W, $clog2(NUM_OUT): width of index outputs.
- clk  in  1  clock; all logic on rising edge.
- rst_b  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse, begins a frame; accepted only in IDLE.
- mult  in  16  unsigned requant multiplier; latched on accepted start.
- shift  in  5  right-shift amount 0..31; latched on accepted start.
- acc_valid  in  1  acc_in valid this cycle; no backpressure.
- acc_in  in  32  signed neuron accumulator, neuron order 0..NUM_OUT-1.
- busy  out  1  high from the cycle after accepted start until done.
- q_valid  out  1  q_data/q_idx valid this cycle.
- q_data  out  8  signed requantized value.
- q_idx  out  IDX_W  neuron index of q_data.
- done  out  1  one-cycle pulse, frame complete.
- class_idx  out  IDX_W  arg-max neuron index; held until the next accepted start.
- class_val  out  8  signed arg-max value; held until the next accepted start.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on start.
  - RUN→DRAIN on the acc_valid that makes the input count equal NUM_OUT.
  - DRAIN→DONE when the last q_valid issues.
  - DONE→IDLE unconditionally after one cycle.
- start outside IDLE is ignored. acc_valid outside RUN is ignored and produces no q_valid.
- in_cnt counts accepted inputs and clears on accepted start. q_idx equals in_cnt at acceptance.
- Stage 1: prod = acc_in × {1'b0,mult}, 49-bit signed, exact.
- Stage 2:
  - if shift = 0, r = prod.
  - otherwise r = (prod + 2^(shift−1)) >>> shift: arithmetic shift, round-half-up toward +∞.
  - saturate r to [−128, 127] to give q_data.
- Arg-max tracking:
  - the first q_valid of a frame loads class_idx/class_val unconditionally.
  - each later q_valid replaces them only if q_data > class_val (strictly greater), so ties keep the lowest index.
- done asserts in the DONE state. class_idx/class_val are final from that cycle onward.
- Reset mid-frame: every register returns to its reset value. The partial frame is discarded. A new start is needed.

## Timing
- Reset values: busy=0, q_valid=0, q_data=0, q_idx=0, done=0, class_idx=0, class_val=0, state=IDLE, in_cnt=0.
- Latency: acc_valid in cycle t gives q_valid in cycle t+2. The block accepts one input per cycle at full throughput.
- The earliest first acc_valid is the cycle after start.
- done asserts exactly one cycle after the last q_valid. busy falls in the same cycle done rises.
- Back-to-back frames: start may be accepted in the cycle after done (state IDLE).
- mult/shift changes while busy have no effect on the current frame.

## Configuration
- Macro: LINEAR_REQUANT_RELU_EN.
- With the macro defined, negative saturated results are clamped to 0 before output and arg-max. q_data range becomes 0..127.
- Without it, the full signed range −128..127 is output.
- Arg-max tie rule and latency are identical in both builds.

## Test plan
- Basic requant, macro off:
  - stimulus: mult=1, shift=0, NUM_OUT=10, acc_in = 0,1,…,9 on consecutive cycles after start.
  - required: q_data = 0..9 with q_idx 0..9, first q_valid 2 cycles after the first acc_valid, done one cycle after q_idx=9, class_idx=9, class_val=9.
- Rounding and saturation:
  - stimulus: mult=3, shift=2, acc_in = 5, −5, 1000, −1000, 6.
  - required: q_data = 4 (15/4=3.75), −4 (−15/4=−3.75), 127, −128, 5 (18/4=4.5).
- Arg-max ties:
  - stimulus: values producing q_data 7, 20, 20, 3, …
  - required: class_idx=1, class_val=20.
- Gapped input and ignored control:
  - stimulus: acc_valid with idle gaps; a second start pulsed mid-frame; acc_valid during IDLE.
  - required: q_idx sequence still 0..NUM_OUT−1, no extra q_valid, a single done.
- Reset mid-frame:
  - stimulus: rst_b low after 4 inputs, then a full new frame.
  - required: all outputs 0 during reset, new frame indices start at 0, class reflects only the new frame.
- ReLU build, macro on:
  - stimulus: mult=1, shift=0, all acc_in negative.
  - required: all q_data=0, class_idx=0, class_val=0.

Source files
------------

// File: rtl/linear_requant_argmax.sv
// linear_requant_argmax
//   Requantizes one frame of NUM_OUT signed 32-bit neuron accumulators to int8
//   (multiply by an unsigned 16-bit scale, rounding arithmetic right shift,
//   saturation), streams the int8 results with their neuron index, and reports
//   the arg-max class index/value when the frame completes.
//
//   Pipeline: accepted acc_valid in cycle t -> product register in t+1 ->
//   q_valid/q_data in t+2. Arg-max is updated in the same edge as q_data.
//
//   Optional build macro: LINEAR_REQUANT_RELU_EN
//     defined   -> negative saturated results are clamped to 0 (ReLU) before
//                  being output and compared for arg-max.
//     undefined -> full signed int8 range -128..127 is output.

module linear_requant_argmax #(
  parameter int NUM_OUT = 10,
  parameter int IDX_W   = $clog2(NUM_OUT)
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    start,
  input  logic [15:0]             mult,
  input  logic [4:0]              shift,
  input  logic                    acc_valid,
  input  logic signed [31:0]      acc_in,
  output logic                    busy,
  output logic                    q_valid,
  output logic signed [7:0]       q_data,
  output logic [IDX_W-1:0]        q_idx,
  output logic                    done,
  output logic [IDX_W-1:0]        class_idx,
  output logic signed [7:0]       class_val
);

  // Counter must be able to hold NUM_OUT itself, which can exceed IDX_W bits.
  localparam int CNT_W = $clog2(NUM_OUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state_reg;
  logic [CNT_W-1:0]        in_cnt_reg;
  logic [15:0]             mult_reg;
  logic [4:0]              shift_reg;

  logic                    s1_valid_reg;
  logic                    s1_last_reg;
  logic [IDX_W-1:0]        s1_idx_reg;
  logic signed [48:0]      prod_reg;

  logic                    q_last_reg;
  logic                    first_reg;

  logic                    start_ok;
  logic                    acc_ok;
  logic                    last_in;

  logic signed [48:0]      acc_ext;
  logic signed [48:0]      mult_ext;
  logic signed [48:0]      prod_next;
  logic signed [49:0]      prod_wide;
  logic signed [49:0]      bias;
  logic signed [49:0]      rounded;
  logic signed [7:0]       sat_val;
  logic signed [7:0]       q_next;

  assign start_ok = (state_reg == IDLE) && start;
  assign acc_ok   = (state_reg == RUN) && acc_valid;
  assign last_in  = acc_ok && (in_cnt_reg == CNT_W'(NUM_OUT - 1));

  // Stage 1 arithmetic: exact 32x17 signed product (mult is zero-extended so
  // it is always treated as positive).
  assign acc_ext   = {{17{acc_in[31]}}, acc_in};
  assign mult_ext  = {33'd0, mult_reg};
  assign prod_next = acc_ext * mult_ext;

  // Stage 2 arithmetic: round-half-up (toward +inf) then arithmetic shift.
  // One extra bit of headroom keeps the bias addition from overflowing.
  assign prod_wide = {prod_reg[48], prod_reg};
  assign bias      = (shift_reg == 5'd0) ? 50'sd0 : (50'sd1 <<< (shift_reg - 5'd1));
  assign rounded   = (prod_wide + bias) >>> shift_reg;

  // Saturate the rounded value to int8, optionally clamping negatives to zero.
  always_comb begin
    if (rounded > 50'sd127) begin
      sat_val = 8'sd127;
    end else if (rounded < -50'sd128) begin
      sat_val = -8'sd128;
    end else begin
      sat_val = rounded[7:0];
    end
`ifdef LINEAR_REQUANT_RELU_EN
    q_next = sat_val[7] ? 8'sd0 : sat_val;
`else
    q_next = sat_val;
`endif
  end

  // Frame control FSM: accepts start, counts inputs, latches scale, and
  // generates registered busy/done.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg  <= IDLE;
      in_cnt_reg <= '0;
      mult_reg   <= '0;
      shift_reg  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg  <= RUN;
            in_cnt_reg <= '0;
            mult_reg   <= mult;
            shift_reg  <= shift;
            busy       <= 1'b1;
          end
        end
        RUN: begin
          if (acc_valid) begin
            in_cnt_reg <= in_cnt_reg + CNT_W'(1);
            if (last_in) begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Last q_valid of the frame is on the output this cycle.
          if (q_valid && q_last_reg) begin
            state_reg <= DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Stage 1 register: capture the product, index and last-of-frame marker.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_idx_reg   <= '0;
      prod_reg     <= '0;
    end else begin
      s1_valid_reg <= acc_ok;
      if (acc_ok) begin
        prod_reg    <= prod_next;
        s1_idx_reg  <= in_cnt_reg[IDX_W-1:0];
        s1_last_reg <= last_in;
      end
    end
  end

  // Stage 2 register: issue the requantized value and track the arg-max.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q_valid    <= 1'b0;
      q_data     <= '0;
      q_idx      <= '0;
      q_last_reg <= 1'b0;
      first_reg  <= 1'b0;
      class_idx  <= '0;
      class_val  <= '0;
    end else begin
      q_valid    <= s1_valid_reg;
      q_last_reg <= s1_valid_reg && s1_last_reg;
      if (s1_valid_reg) begin
        q_data <= q_next;
        q_idx  <= s1_idx_reg;
      end
      if (start_ok) begin
        first_reg <= 1'b1;
      end else if (s1_valid_reg) begin
        first_reg <= 1'b0;
        // Strictly greater keeps the lowest index on ties.
        if (first_reg || (q_next > class_val)) begin
          class_idx <= s1_idx_reg;
          class_val <= q_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_linear_requant_argmax.sv
// Testbench for linear_requant_argmax: directed frames with hand-computed
// expected int8 results, latency, done/busy timing, arg-max and reset checks.
// Build with LINEAR_REQUANT_RELU_EN defined to exercise the ReLU variant.

module tb_linear_requant_argmax;

  localparam int N  = 10;
  localparam int IW = $clog2(N);

  logic               clk;
  logic               rst_b;
  logic               start;
  logic [15:0]        mult;
  logic [4:0]         shift;
  logic               acc_valid;
  logic signed [31:0] acc_in;
  logic               busy;
  logic               q_valid;
  logic signed [7:0]  q_data;
  logic [IW-1:0]      q_idx;
  logic               done;
  logic [IW-1:0]      class_idx;
  logic signed [7:0]  class_val;

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int first_acc_cyc = 0;

  // Output capture written by the monitor only
  logic signed [7:0]  cap_data [512];
  logic [IW-1:0]      cap_idx  [512];
  int                 cap_cyc  [512];
  int                 cap_n = 0;
  int                 done_n = 0;
  int                 done_cyc = 0;
  logic               busy_at_done = 1'b1;

  logic signed [31:0] stim [N];

  linear_requant_argmax #(.NUM_OUT(N)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .mult(mult), .shift(shift),
    .acc_valid(acc_valid), .acc_in(acc_in), .busy(busy), .q_valid(q_valid),
    .q_data(q_data), .q_idx(q_idx), .done(done), .class_idx(class_idx),
    .class_val(class_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_b) begin
      if (q_valid) begin
        cap_data[cap_n] <= q_data;
        cap_idx[cap_n]  <= q_idx;
        cap_cyc[cap_n]  <= cyc;
        cap_n           <= cap_n + 1;
        $display("q   : cyc=%0d idx=%0d data=%0d", cyc, q_idx, q_data);
      end
      if (done) begin
        done_n       <= done_n + 1;
        done_cyc     <= cyc;
        busy_at_done <= busy;
        $display("done: cyc=%0d class_idx=%0d class_val=%0d", cyc, class_idx, class_val);
      end
    end
  end

  function automatic int rl(input int v);
`ifdef LINEAR_REQUANT_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Wait (bounded) for done; ends #1 after the negedge of the done cycle.
  task automatic wait_done(input string name);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (done !== 1'b1 && t < 80);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: done not seen within %0d cycles (required done=1)", name, t);
    end
    #1;
  endtask

  // Start a frame and drive stim[] back-to-back; scale inputs are scrambled
  // after start to show they are latched.
  task automatic drive_frame(input logic [15:0] m, input logic [4:0] s,
                             input string name, output int base);
    @(posedge clk); #1;
    base  = cap_n;
    start = 1'b1; mult = m; shift = s;
    @(posedge clk); #1;
    start = 1'b0; mult = 16'h0000; shift = 5'd31;
    for (int i = 0; i < N; i++) begin
      acc_valid = 1'b1;
      acc_in    = stim[i];
      if (i == 0) first_acc_cyc = cyc;
      @(posedge clk); #1;
    end
    acc_valid = 1'b0;
    acc_in    = '0;
    wait_done(name);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({busy, q_valid, q_data, q_idx, done, class_idx, class_val} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b qv=%b qd=%0d qi=%0d done=%b ci=%0d cv=%0d required all 0",
               busy, q_valid, q_data, q_idx, done, class_idx, class_val);
    end
    @(posedge clk); #1;
    rst_b = 1'b1;
  endtask

  task automatic test_basic;
    int base;
    for (int i = 0; i < N; i++) stim[i] = i;
    drive_frame(16'd1, 5'd0, "basic", base);
    checks++;
    if (cap_n - base !== N) begin
      errors++;
      $display("FAIL basic_count: got %0d q_valid required %0d", cap_n - base, N);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (cap_data[base+i] !== 8'(i) || cap_idx[base+i] !== IW'(i)) begin
        errors++;
        $display("FAIL basic_q[%0d]: got data=%0d idx=%0d required data=%0d idx=%0d",
                 i, cap_data[base+i], cap_idx[base+i], i, i);
      end
    end
    checks++;
    if (cap_cyc[base] - first_acc_cyc !== 2) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles required 2", cap_cyc[base] - first_acc_cyc);
    end
    checks++;
    if (done_cyc !== cap_cyc[base+N-1] + 1) begin
      errors++;
      $display("FAIL basic_done_timing: got done at %0d required %0d", done_cyc, cap_cyc[base+N-1] + 1);
    end
    checks++;
    if (busy_at_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_at_done: got %b required 0", busy_at_done);
    end
    checks++;
    if (class_idx !== IW'(9) || class_val !== 8'sd9) begin
      errors++;
      $display("FAIL basic_class: got idx=%0d val=%0d required idx=9 val=9", class_idx, class_val);
    end
  endtask

  task automatic test_round_sat;
    int base;
    int e[N] = '{4, -4, 127, -128, 5, 0, 1, -1, 0, 0};
    int v[N] = '{5, -5, 1000, -1000, 6, 0, 1, -2, -1, 0};
    // -2*3=-6, +2=-4, >>>2 = -1 ; -1*3=-3, +2=-1, >>>2 = -1 -> wait: see e[8]
    // 1*3=3, +2=5, >>>2 = 1
    e[8] = -1;
    for (int i = 0; i < N; i++) stim[i] = v[i];
    drive_frame(16'd3, 5'd2, "round", base);
    checks++;
    if (cap_n - base !== N) begin
      errors++;
      $display("FAIL round_count: got %0d q_valid required %0d", cap_n - base, N);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (cap_data[base+i] !== 8'(rl(e[i]))) begin
        errors++;
        $display("FAIL round_q[%0d]: got %0d required %0d", i, cap_data[base+i], rl(e[i]));
      end
    end
    checks++;
    if (class_idx !== IW'(2) || class_val !== 8'sd127) begin
      errors++;
      $display("FAIL round_class: got idx=%0d val=%0d required idx=2 val=127", class_idx, class_val);
    end
  endtask

  task automatic test_ties;
    int base;
    int v[N] = '{7, 20, 20, 3, 1, 2, 20, 19, 0, 5};
    for (int i = 0; i < N; i++) stim[i] = v[i];
    drive_frame(16'd1, 5'd0, "ties", base);
    checks++;
    if (class_idx !== IW'(1) || class_val !== 8'sd20) begin
      errors++;
      $display("FAIL ties_class: got idx=%0d val=%0d required idx=1 val=20", class_idx, class_val);
    end
  endtask

  task automatic test_gapped;
    int base;
    int d0;
    int v[N] = '{3, -2, 40, 7, 40, -100, -200, 0, 1, 2};
    int e[N] = '{3, -2, 40, 7, 40, -100, -128, 0, 1, 2};
    @(posedge clk); #1;
    base = cap_n;
    d0   = done_n;
    // acc_valid while idle must be ignored
    acc_valid = 1'b1; acc_in = 32'sd77;
    @(posedge clk); #1;
    @(posedge clk); #1;
    acc_valid = 1'b0;
    start = 1'b1; mult = 16'd1; shift = 5'd0;
    @(posedge clk); #1;
    start = 1'b0; mult = 16'd0;
    for (int i = 0; i < N; i++) begin
      acc_valid = 1'b1;
      acc_in    = v[i];
      if (i == 4) start = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      acc_valid = 1'b0;
      if (i % 2 == 0) begin
        @(posedge clk); #1;
        @(posedge clk); #1;
      end
    end
    wait_done("gapped");
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (cap_n - base !== N) begin
      errors++;
      $display("FAIL gapped_count: got %0d q_valid required %0d", cap_n - base, N);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (cap_idx[base+i] !== IW'(i) || cap_data[base+i] !== 8'(rl(e[i]))) begin
        errors++;
        $display("FAIL gapped_q[%0d]: got idx=%0d data=%0d required idx=%0d data=%0d",
                 i, cap_idx[base+i], cap_data[base+i], i, rl(e[i]));
      end
    end
    checks++;
    if (done_n - d0 !== 1) begin
      errors++;
      $display("FAIL gapped_done_count: got %0d required 1", done_n - d0);
    end
    checks++;
    if (class_idx !== IW'(2) || class_val !== 8'sd40) begin
      errors++;
      $display("FAIL gapped_class: got idx=%0d val=%0d required idx=2 val=40", class_idx, class_val);
    end
  endtask

  task automatic test_reset_mid;
    int base;
    int v[N] = '{5, 4, 3, 2, 1, 0, -1, -2, -3, 6};
    @(posedge clk); #1;
    start = 1'b1; mult = 16'd1; shift = 5'd0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      acc_valid = 1'b1;
      acc_in    = 100 + i;
      @(posedge clk); #1;
    end
    acc_valid = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, q_valid, q_data, q_idx, done, class_idx, class_val} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%b qv=%b qd=%0d qi=%0d done=%b ci=%0d cv=%0d required all 0",
               busy, q_valid, q_data, q_idx, done, class_idx, class_val);
    end
    @(posedge clk); #1;
    rst_b = 1'b1;
    for (int i = 0; i < N; i++) stim[i] = v[i];
    drive_frame(16'd1, 5'd0, "midreset", base);
    checks++;
    if (cap_n - base !== N || cap_idx[base] !== IW'(0)) begin
      errors++;
      $display("FAIL midreset_frame: got count=%0d first_idx=%0d required count=%0d first_idx=0",
               cap_n - base, cap_idx[base], N);
    end
    checks++;
    if (class_idx !== IW'(9) || class_val !== 8'sd6) begin
      errors++;
      $display("FAIL midreset_class: got idx=%0d val=%0d required idx=9 val=6", class_idx, class_val);
    end
  endtask

`ifdef LINEAR_REQUANT_RELU_EN
  task automatic test_relu;
    int base;
    int v[N] = '{-1, -5, -100, -1000, -3, -2, -7, -9, -50, -4};
    for (int i = 0; i < N; i++) stim[i] = v[i];
    drive_frame(16'd1, 5'd0, "relu", base);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (cap_data[base+i] !== 8'sd0) begin
        errors++;
        $display("FAIL relu_q[%0d]: got %0d required 0", i, cap_data[base+i]);
      end
    end
    checks++;
    if (class_idx !== IW'(0) || class_val !== 8'sd0) begin
      errors++;
      $display("FAIL relu_class: got idx=%0d val=%0d required idx=0 val=0", class_idx, class_val);
    end
  endtask
`endif

  initial begin
    rst_b     = 1'b0;
    start     = 1'b0;
    mult      = '0;
    shift     = '0;
    acc_valid = 1'b0;
    acc_in    = '0;
    test_reset();
    test_basic();
    test_round_sat();
    test_ties();
    test_gapped();
    test_reset_mid();
`ifdef LINEAR_REQUANT_RELU_EN
    test_relu();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
